pulse_level_driver: RTL

//   Output-side counterpart of the input debouncer: turns single-cycle event requests into

---
 rtl/pulse_level_driver.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_level_driver.sv
// -----------------------------------------------------------------------------
// pulse_level_driver
//
// Purpose
//   Output-side counterpart of an input debouncer. Single-cycle event requests
//   become clean, timed level pulses on an external pin, for key emulation or a
//   slave handshake line. Every pulse is held active for exactly ACTIVE_CYC
//   cycles and is followed by at least GAP_CYC inactive cycles, so a far-end
//   debouncer always accepts it. Requests that arrive while a pulse is in
//   progress are queued in a saturating pending counter.
//
// Ports
//   clk            in   1       clock
//   rst_n          in   1       asynchronous, active-low reset
//   i_pulse_req    in   1       one-cycle request for one pulse
//   i_abort        in   1       one-cycle: flush queue, end current pulse,
//                               clear overflow
//   o_pin_out      out  1       registered pin drive
//   o_pin_assert   out  1       one-cycle flag, cycle after pin goes active
//   o_pin_release  out  1       one-cycle flag, cycle after pin returns idle
//   o_busy         out  1       pulse/gap in progress or requests queued
//   o_pend_cnt     out  PEND_W  queued requests not yet started
//   o_overflow     out  1       sticky: a request was dropped
//   o_pulse_cnt    out  16      completed full-width pulses (PULSE_CNT_EN only)
//
// Build option
//   PULSE_CNT_EN   when defined, adds o_pulse_cnt: a wrapping 16-bit count of
//                  pulses that ran their full active width. Pulses cut short
//                  by abort are not counted, and abort does not clear it.
//
// FSM states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | pin idle, nothing in progress; starts a pulse if queued
//   ST_ACTIVE | pin active, timer counts the active width
//   ST_GAP    | pin idle, timer enforces the minimum inactive width
// -----------------------------------------------------------------------------
module pulse_level_driver #(
  parameter int unsigned N          = 32,
  parameter int unsigned ACTIVE_CYC = 500,
  parameter int unsigned GAP_CYC    = 500,
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pulse_req,
  input  logic              i_abort,
  output logic              o_pin_out,
  output logic              o_pin_assert,
  output logic              o_pin_release,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pend_cnt,
  output logic              o_overflow
`ifdef PULSE_CNT_EN
  ,
  output logic [15:0]       o_pulse_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [N-1:0]      ACT_LAST   = N'(ACTIVE_CYC - 1);
  localparam logic [N-1:0]      GAP_LAST   = N'(GAP_CYC - 1);
  localparam logic [N-1:0]      TIMER_ONE  = N'(1);
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);
  localparam logic              PIN_ACTIVE = ~IDLE_LEVEL;

  // Registered state
  state_t            r_state;
  logic [N-1:0]      r_timer;
  logic [PEND_W-1:0] r_pend;
  logic              r_overflow;
  logic              r_pin;
  logic              r_pin_d0;
  logic              r_pin_assert;
  logic              r_pin_release;

  // Combinational next values
  state_t            w_state_nxt;
  logic [N-1:0]      w_timer_nxt;
  logic              w_pin_nxt;
  logic              w_dequeue;
  logic              w_pend_nz;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              w_overflow_nxt;

  assign w_pend_nz = (r_pend != '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_pin   <= IDLE_LEVEL;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_pin   <= w_pin_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, timer and pin drive
  // ---------------------------------------------------------------------------
  // An abort suppresses the dequeue in IDLE and at the end of GAP, because the
  // same edge flushes the queue. During GAP an abort leaves the timer running
  // so the minimum inactive width is still honoured.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pin_nxt   = r_pin;
    w_dequeue   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_pin_nxt   = IDLE_LEVEL;
        w_timer_nxt = '0;
        if (w_pend_nz && !i_abort) begin
          w_state_nxt = ST_ACTIVE;
          w_pin_nxt   = PIN_ACTIVE;
          w_dequeue   = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (i_abort || (r_timer == ACT_LAST)) begin
          w_state_nxt = ST_GAP;
          w_timer_nxt = '0;
          w_pin_nxt   = IDLE_LEVEL;
        end else begin
          w_timer_nxt = r_timer + TIMER_ONE;
          w_pin_nxt   = PIN_ACTIVE;
        end
      end

      ST_GAP: begin
        w_pin_nxt = IDLE_LEVEL;
        if (r_timer == GAP_LAST) begin
          w_timer_nxt = '0;
          // Chain straight into the next pulse: no extra idle cycle.
          if (w_pend_nz && !i_abort) begin
            w_state_nxt = ST_ACTIVE;
            w_pin_nxt   = PIN_ACTIVE;
            w_dequeue   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + TIMER_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_pin_nxt   = IDLE_LEVEL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending queue and overflow
  // ---------------------------------------------------------------------------
  // A request and a dequeue in the same cycle cancel out, so a request is only
  // dropped when the counter is full and nothing leaves the queue that cycle.
  always_comb begin
    w_pend_nxt     = r_pend;
    w_overflow_nxt = r_overflow;

    if (i_abort) begin
      w_pend_nxt     = '0;
      w_overflow_nxt = 1'b0;
    end else if (i_pulse_req && !w_dequeue) begin
      if (r_pend == PEND_MAX) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_pend_nxt = r_pend + PEND_ONE;
      end
    end else if (!i_pulse_req && w_dequeue) begin
      w_pend_nxt = r_pend - PEND_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin edge flags, derived from the registered pin one cycle late
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin_d0      <= IDLE_LEVEL;
      r_pin_assert  <= 1'b0;
      r_pin_release <= 1'b0;
    end else begin
      r_pin_d0      <= r_pin;
      r_pin_assert  <= (r_pin_d0 == IDLE_LEVEL) && (r_pin != IDLE_LEVEL);
      r_pin_release <= (r_pin_d0 != IDLE_LEVEL) && (r_pin == IDLE_LEVEL);
    end
  end

`ifdef PULSE_CNT_EN
  // ---------------------------------------------------------------------------
  // Completed-pulse counter: only a timer expiry in ACTIVE counts
  // ---------------------------------------------------------------------------
  logic        w_pulse_done;
  logic [15:0] r_pulse_cnt;

  assign w_pulse_done = (r_state == ST_ACTIVE) && !i_abort && (r_timer == ACT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_cnt <= '0;
    end else if (w_pulse_done) begin
      r_pulse_cnt <= r_pulse_cnt + 16'd1;
    end
  end

  assign o_pulse_cnt = r_pulse_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_pin_out     = r_pin;
  assign o_pin_assert  = r_pin_assert;
  assign o_pin_release = r_pin_release;
  assign o_pend_cnt    = r_pend;
  assign o_overflow    = r_overflow;
  assign o_busy        = (r_state != ST_IDLE) || w_pend_nz;

endmodule
